// File: rtl/chunk_pkg.sv
// chunk_pkg: phase enum shared by the chunk splitter and dechunker.
package chunk_pkg;
    typedef enum logic {IDLE, FILL} phase_e;
endpackage

// File: rtl/dechunker.sv
// dechunker: reassembles contiguous bursts of M-bit chunks into L-bit blocks, first chunk in the MSBs.
module dechunker
    import chunk_pkg::*;
#(
    parameter int L = 128,
    parameter int M = 32,
    localparam int NR = L / M,
    localparam int CW = $clog2(NR + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [M-1:0]  d,
    input  logic          valid,
    input  logic          clear,
    output logic [L-1:0]  data_out,
    output logic          strobe,
    output logic          abort,
    output logic          busy,
    output logic [CW-1:0] count
);
    if (L % M != 0 || L < M) begin : g_bad_params
        $error("dechunker: L must be a non-zero multiple of M");
    end
    logic [L-1:0]  sr_q, sr_d, data_q, data_d;
    logic [CW-1:0] count_q, count_d, base;
    logic          strobe_q, strobe_d, abort_q, abort_d;
    logic [L-1:0]  shifted;
    phase_e        phase;
    assign phase   = (count_q == '0) ? IDLE : FILL;
    assign base    = clear ? '0 : count_q;
    // Truncating the concatenation keeps {sr[L-M-1:0], d}, and still works when NR=1.
    assign shifted = L'({sr_q, d});
    always_comb begin
        sr_d     = valid ? shifted : sr_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        abort_d  = 1'b0;
        count_d  = base;
        if (valid && base == CW'(NR - 1)) begin
            data_d   = shifted;
            strobe_d = 1'b1;
            count_d  = '0;
        end else if (valid) begin
            count_d = base + 1'b1;
        end else if (!clear && phase == FILL) begin
            abort_d = 1'b1;
            count_d = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q     <= '0;
            data_q   <= '0;
            count_q  <= '0;
            strobe_q <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            data_q   <= data_d;
            count_q  <= count_d;
            strobe_q <= strobe_d;
            abort_q  <= abort_d;
        end
    end
    assign data_out = data_q;
    assign strobe   = strobe_q;
    assign abort    = abort_q;
    assign count    = count_q;
    assign busy     = phase == FILL;
endmodule

// File: tb/tb_dechunker.sv
// tb_dechunker: directed scoreboard bench for dechunker at L=128/M=32 and at L=M=32.
module tb_dechunker;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  d = '0, d2 = '0;
    logic         valid = 1'b0, valid2 = 1'b0, clear = 1'b0;
    logic [127:0] data_out;
    logic [31:0]  data_out2;
    logic         strobe, abort, busy, strobe2, abort2, busy2;
    logic [2:0]   count;
    logic [0:0]   count2;
    int           vectors = 0, miscompares = 0;
    int           aborts = 0, exp_aborts = 0, aborts2 = 0;
    logic [127:0] exp_q[$];
    logic [31:0]  exp2_q[$];

    always #5 clk = ~clk;

    dechunker #(.L(128), .M(32)) dut (
        .clk(clk), .reset(reset), .d(d), .valid(valid), .clear(clear),
        .data_out(data_out), .strobe(strobe), .abort(abort), .busy(busy), .count(count)
    );

    dechunker #(.L(32), .M(32)) dut1 (
        .clk(clk), .reset(reset), .d(d2), .valid(valid2), .clear(1'b0),
        .data_out(data_out2), .strobe(strobe2), .abort(abort2), .busy(busy2), .count(count2)
    );

    function automatic void chk(input string n, input logic [127:0] a, input logic [127:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endfunction

    task automatic cyc(input logic [31:0] dd, input logic vv, input logic cc);
        d = dd;
        valid = vv;
        clear = cc;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (strobe) begin
                if (exp_q.size() == 0) chk("strobe_unexpected", 128'(strobe), 128'd0);
                else chk("block", data_out, exp_q.pop_front());
            end
            if (abort) aborts++;
            if (strobe && abort) chk("strobe_and_abort", 128'd1, 128'd0);
            if (strobe2) begin
                if (exp2_q.size() == 0) chk("strobe1_unexpected", 128'(strobe2), 128'd0);
                else chk("block_nr1", 128'(data_out2), 128'(exp2_q.pop_front()));
            end
            if (abort2) aborts2++;
            if (busy2) chk("busy_nr1", 128'(busy2), 128'd0);
        end
    end

    initial begin
        logic [127:0] w;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_strobe", 128'(strobe), 0);
        chk("rst_abort", 128'(abort), 0);
        chk("rst_busy", 128'(busy), 0);
        chk("rst_count", 128'(count), 0);
        reset = 1'b0;
        cyc(0, 0, 0);

        exp_q.push_back(128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
        cyc(32'hAAAAAAAA, 1, 0);
        cyc(32'hBBBBBBBB, 1, 0);
        chk("count_after_2", 128'(count), 2);
        chk("busy_after_2", 128'(busy), 1);
        cyc(32'hCCCCCCCC, 1, 0);
        cyc(32'hDDDDDDDD, 1, 0);
        chk("strobe_abcd", 128'(strobe), 1);
        chk("count_after_block", 128'(count), 0);
        cyc(0, 0, 0);
        chk("strobe_one_cycle", 128'(strobe), 0);

        exp_q.push_back({32'd1, 32'd2, 32'd3, 32'd4});
        exp_q.push_back({32'd5, 32'd6, 32'd7, 32'd8});
        for (int i = 1; i <= 8; i++) begin
            cyc(i, 1, 0);
            if (i % 4 == 0) chk($sformatf("b2b_strobe_%0d", i), 128'(strobe), 1);
            else chk($sformatf("b2b_nostrobe_%0d", i), 128'(strobe), 0);
        end
        cyc(0, 0, 0);

        cyc(32'h11111111, 1, 0);
        cyc(32'h22222222, 1, 0);
        exp_aborts++;
        cyc(0, 0, 0);
        chk("gap_abort", 128'(abort), 1);
        chk("gap_count", 128'(count), 0);
        exp_q.push_back(128'h57575757_58585858_59595959_5A5A5A5A);
        cyc(32'h57575757, 1, 0);
        chk("abort_one_cycle", 128'(abort), 0);
        cyc(32'h58585858, 1, 0);
        cyc(32'h59595959, 1, 0);
        cyc(32'h5A5A5A5A, 1, 0);
        cyc(0, 0, 0);

        exp_q.push_back(128'hC3C3C3C3_D0D0D0D0_D1D1D1D1_D2D2D2D2);
        cyc(32'hC0C0C0C0, 1, 0);
        cyc(32'hC1C1C1C1, 1, 0);
        cyc(32'hC2C2C2C2, 1, 0);
        cyc(32'hC3C3C3C3, 1, 1);
        chk("clear_count", 128'(count), 1);
        chk("clear_no_abort", 128'(abort), 0);
        cyc(32'hD0D0D0D0, 1, 0);
        cyc(32'hD1D1D1D1, 1, 0);
        cyc(32'hD2D2D2D2, 1, 0);
        cyc(0, 0, 0);

        cyc(32'hEEEEEEEE, 1, 0);
        cyc(32'hEEEEEEEE, 1, 0);
        reset = 1'b1;
        cyc(0, 0, 0);
        reset = 1'b0;
        chk("midrst_data_out", data_out, 0);
        chk("midrst_strobe", 128'(strobe), 0);
        chk("midrst_abort", 128'(abort), 0);
        chk("midrst_busy", 128'(busy), 0);
        chk("midrst_count", 128'(count), 0);
        exp_q.push_back(128'h01234567_89ABCDEF_FEDCBA98_76543210);
        cyc(32'h01234567, 1, 0);
        cyc(32'h89ABCDEF, 1, 0);
        cyc(32'hFEDCBA98, 1, 0);
        cyc(32'h76543210, 1, 0);
        cyc(0, 0, 0);

        for (int n = 0; n < 6; n++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            exp_q.push_back(w);
            for (int i = 0; i < 4; i++) cyc(w[127 - 32*i -: 32], 1, 0);
            cyc(0, 0, 0);
            cyc(0, 0, 0);
        end

        for (int n = 0; n < 8; n++) begin
            d2 = $urandom;
            valid2 = 1'b1;
            exp2_q.push_back(d2);
            cyc(0, 0, 0);
            valid2 = 1'b0;
            cyc(0, 0, 0);
            cyc(0, 0, 0);
        end
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        chk("abort_total", 128'(aborts), 128'(exp_aborts));
        chk("abort_total_nr1", 128'(aborts2), 0);
        chk("pending_blocks", 128'(exp_q.size()), 0);
        chk("pending_blocks_nr1", 128'(exp2_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
